// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: decoder FSM states, default lane/window sizes
// and the bipolar count mapping used by sc_stream_decoder.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } sc_dec_state_t;

   localparam int SC_WIDTH  = 16;
   localparam int SC_WINDOW = 16;

   // A ones-count c over a window of n samples encodes the bipolar value 2c - n.
   function automatic int sc_bipolar(input int count, input int window);
      return 2 * count - window;
   endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// One lane's ones-accumulator for the stochastic decoder. The count never exceeds the
// window length, so CNT_W is always wide enough and no wrap can occur.
module sc_lane_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             lane_bit,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(lane_bit);
      end
   end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones per lane over WINDOW valid samples.
// Define SC_DEC_BIPOLAR_EN to present signed 2*count-WINDOW results instead of raw counts.
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int WIDTH  = SC_WIDTH,
   parameter int WINDOW = SC_WINDOW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [WIDTH-1:0]        in,
   output logic                    busy,
   output logic                    done,
`ifdef SC_DEC_BIPOLAR_EN
   output logic [WIDTH*($clog2(WINDOW+1)+1)-1:0] result
`else
   output logic [WIDTH*$clog2(WINDOW+1)-1:0]     result
`endif
);

   localparam int CNT_W = $clog2(WINDOW + 1);
`ifdef SC_DEC_BIPOLAR_EN
   localparam int RES_W = CNT_W + 1;
`else
   localparam int RES_W = CNT_W;
`endif

   sc_dec_state_t          state;
   logic [CNT_W-1:0]       sample_cnt;
   logic                   start_accept;
   logic                   lane_en;
   logic                   last_sample;
   logic [CNT_W-1:0]       lane_count [WIDTH];
   logic [WIDTH*RES_W-1:0] result_next;

   assign start_accept = start && ((state == IDLE) || (state == DONE));
   assign lane_en      = (state == ACCUM) && in_valid;
   assign last_sample  = lane_en && (sample_cnt == CNT_W'(WINDOW - 1));

   // result_next folds in the current sample so the final count is captured on the same edge.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic [CNT_W-1:0] lane_sum;

      sc_lane_counter #(
         .CNT_W (CNT_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (start_accept),
         .en       (lane_en),
         .lane_bit (in[i]),
         .count    (lane_count[i])
      );

      assign lane_sum = lane_count[i] + CNT_W'(in[i]);

`ifdef SC_DEC_BIPOLAR_EN
      assign result_next[i*RES_W +: RES_W] = RES_W'(sc_bipolar(int'(lane_sum), WINDOW));
`else
      assign result_next[i*RES_W +: RES_W] = lane_sum;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_accept) begin
                  state      <= ACCUM;
                  sample_cnt <= '0;
                  busy       <= 1'b1;
               end
            end
            ACCUM: begin
               if (lane_en) begin
                  sample_cnt <= sample_cnt + CNT_W'(1);
               end
               if (last_sample) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= result_next;
               end
            end
            DONE: begin
               if (start_accept) begin
                  state      <= ACCUM;
                  sample_cnt <= '0;
                  busy       <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
